// File: rtl/i2c_write_master.sv
// i2c_write_master
//   Write-only I2C bus master for codec/peripheral configuration. On an
//   accepted start it sends START, {DEV_ADDR,W}, NBYTES payload bytes (MSB
//   first) and STOP. Every ACK slot is checked, and a NACK aborts with STOP.
//   Slave clock stretching is honoured in the SCL-high quarter.
//
// Ports
//   clk, reset      system clock, synchronous active-low reset
//   start           request a transaction (ignored while busy)
//   wdata           payload, byte 0 = wdata[8*NBYTES-1 -: 8], sent first
//   busy            transaction in progress
//   done            one-cycle pulse at the end of a transaction (ok or abort)
//   nack            last transaction aborted on NACK (held until next start)
//   nack_byte       index of the NACKed byte (0 = address byte)
//   scl_oe, sda_oe  1 = pull the open-drain line low
//   scl_in, sda_in  asynchronous pad readback
`timescale 1ns/1ps
module i2c_write_master #(
    parameter int         CLK_DIV  = 5000,   // clk cycles per SCL quarter, >= 4
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NBYTES   = 2       // 1..15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  nack,
    output logic [3:0]            nack_byte,
    output logic                  scl_oe,
    input  logic                  scl_in,
    output logic                  sda_oe,
    input  logic                  sda_in
);

    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          q, q_nxt;
    logic [DW-1:0]       div;
    logic [1:0]          scl_sync, sda_sync;
    logic                scl_s, sda_s;
    logic                tick, hold, accept, last_q;
    logic                scl_oe_nxt, sda_oe_nxt;
    logic [7:0]          cur_byte;
    logic [8*NBYTES-1:0] payload;
    logic [2:0]          bit_cnt;
    logic [3:0]          byte_idx;
    logic                acked;

    assign scl_s  = scl_sync[1];
    assign sda_s  = sda_sync[1];
    assign accept = (state == S_IDLE) && start;

    // Stretching: only in the SCL-high quarter, and only once the divider has
    // run long enough for our own release to reach the synchroniser output.
    assign hold   = (state != S_IDLE) && (q == 2'd2) && (div >= DW'(3)) && !scl_s;
    assign tick   = (state != S_IDLE) && (div == DW'(CLK_DIV - 1)) && !hold;
    assign last_q = tick && (q == 2'd3);

    // Pad synchronisers; reset to the idle (released, high) level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

    // Quarter-period divider, parked at 0 while idle.
    always_ff @(posedge clk) begin
        if (!reset || state == S_IDLE) begin
            div <= '0;
        end else if (!hold) begin
            div <= tick ? '0 : div + DW'(1);
        end
    end

    // FSM state register and registered line drivers / status.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            q      <= 2'd0;
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            scl_oe <= scl_oe_nxt;
            sda_oe <= sda_oe_nxt;
            busy   <= (state_nxt != S_IDLE);
            done   <= (state == S_STOP) && last_q;
        end
    end

    // Next state, next quarter, and the line levels for the upcoming quarter.
    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        scl_oe_nxt = scl_oe;
        sda_oe_nxt = sda_oe;

        if (tick) q_nxt = q + 2'd1;

        case (state)
            S_IDLE: begin
                q_nxt = 2'd0;
                if (start) state_nxt = S_START;
            end
            S_START: if (last_q) state_nxt = S_BIT;
            S_BIT:   if (last_q && bit_cnt == 3'd7) state_nxt = S_ACK;
            S_ACK: begin
                if (last_q) begin
                    if (!acked || byte_idx == 4'(NBYTES)) state_nxt = S_STOP;
                    else                                 state_nxt = S_BIT;
                end
            end
            S_STOP:  if (last_q) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Lines only change on quarter boundaries (or when leaving idle).
        if (tick || accept) begin
            case (state_nxt)
                S_IDLE: begin
                    scl_oe_nxt = 1'b0;
                    sda_oe_nxt = 1'b0;
                end
                S_START: begin
                    scl_oe_nxt = 1'b0;
                    sda_oe_nxt = q_nxt[1];
                end
                S_BIT: begin
                    scl_oe_nxt = ~q_nxt[1];
                    // Data changes one quarter after SCL falls.
                    if (q_nxt == 2'd1) sda_oe_nxt = ~cur_byte[7];
                end
                S_ACK: begin
                    scl_oe_nxt = ~q_nxt[1];
                    if (q_nxt == 2'd1) sda_oe_nxt = 1'b0;
                end
                S_STOP: begin
                    scl_oe_nxt = (q_nxt == 2'd0);
                    sda_oe_nxt = (q_nxt != 2'd3);
                end
                default: begin
                    scl_oe_nxt = 1'b0;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Byte/bit sequencing and ACK bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_byte  <= 8'h00;
            payload   <= '0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 4'd0;
            acked     <= 1'b0;
            nack      <= 1'b0;
            nack_byte <= 4'd0;
        end else if (accept) begin
            cur_byte <= {DEV_ADDR, 1'b0};
            payload  <= wdata;
            bit_cnt  <= 3'd0;
            byte_idx <= 4'd0;
            nack     <= 1'b0;
        end else if (tick) begin
            if (state == S_BIT && q == 2'd3) begin
                cur_byte <= {cur_byte[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;        // wraps to 0 after bit 7
            end
            if (state == S_ACK && q == 2'd2) acked <= ~sda_s;
            if (state == S_ACK && q == 2'd3) begin
                if (!acked) begin
                    nack      <= 1'b1;
                    nack_byte <= byte_idx;
                end else if (byte_idx != 4'(NBYTES)) begin
                    cur_byte <= payload[8*NBYTES-1 -: 8];
                    payload  <= payload << 8;
                    byte_idx <= byte_idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Scoreboard bench for i2c_write_master: a bus-level slave model decodes the
// wire, the driver pushes expected outcomes, the monitor checks on each done.
`timescale 1ns/1ps
module tb_i2c_write_master;

    localparam int         CD  = 4;
    localparam int         NB  = 2;
    localparam logic [6:0] DEV = 7'h1A;

    logic            clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [8*NB-1:0] wdata = '0;
    logic            busy, done, nack, scl_oe, sda_oe, scl_in, sda_in;
    logic [3:0]      nack_byte;
    logic            slave_scl_low = 1'b0, slave_sda_low = 1'b0;

    assign scl_in = ~scl_oe & ~slave_scl_low;
    assign sda_in = ~sda_oe & ~slave_sda_low;

    i2c_write_master #(.CLK_DIV(CD), .DEV_ADDR(DEV), .NBYTES(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .wdata(wdata),
        .busy(busy), .done(done), .nack(nack), .nack_byte(nack_byte),
        .scl_oe(scl_oe), .scl_in(scl_in), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nerr = 0;

    task automatic chk(input string name, input int act, input int expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        nvec++;
        if (act < lo || act > hi) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Expected outcome of one accepted transaction.
    typedef struct {
        logic [8*NB-1:0] w;
        int              nwire;
        bit              nkf;
        int              nki;
        int              lo, hi;
        int              accept;
    } exp_t;

    exp_t exp_q[$];
    int   last_accept = 0;

    function automatic int lat_for(input int k);
        return 4*CD*(2 + 9*(k+1));
    endfunction

    // ---------------- slave / bus model ----------------
    int         nack_at = -1;
    bit         stretch_armed = 0;
    logic [7:0] obs_q[$];
    int         start_cnt = 0, stop_cnt = 0, bitcnt = 0;
    bit         in_frame = 0;
    logic [7:0] shreg = 8'h00;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         stretch_cnt = 0, stretch_done = 0;
    logic       stretch_sda = 1'b1;
    bit         stretch_bad = 0;

    initial begin : slave
        logic scl_l, sda_l;
        forever begin
            @(negedge clk);
            // Hold SCL low for 50 cycles from the moment the master releases it for bit 3 of byte 1.
            if (stretch_armed && in_frame && obs_q.size() == 1 && bitcnt == 3 && !scl_oe && !prev_scl) begin
                slave_scl_low = 1'b1;
                stretch_cnt   = 50;
                stretch_armed = 0;
                stretch_sda   = ~sda_oe & ~slave_sda_low;
            end
            scl_l = ~scl_oe & ~slave_scl_low;
            sda_l = ~sda_oe & ~slave_sda_low;
            if (slave_scl_low) begin
                if (sda_l !== stretch_sda) stretch_bad = 1;
                stretch_cnt--;
                if (stretch_cnt == 0) begin
                    slave_scl_low = 1'b0;
                    stretch_done++;
                end
            end
            if (prev_scl && scl_l) begin
                if (prev_sda && !sda_l) begin
                    start_cnt++;
                    in_frame = 1;
                    bitcnt   = 0;
                end else if (!prev_sda && sda_l && in_frame) begin
                    stop_cnt++;
                    in_frame = 0;
                end
            end else if (!prev_scl && scl_l && in_frame) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], sda_l};
                    bitcnt++;
                    if (bitcnt == 8) obs_q.push_back(shreg);
                end else begin
                    bitcnt = 0;                   // ninth (ACK) clock
                end
            end else if (prev_scl && !scl_l && in_frame) begin
                if (bitcnt == 8) slave_sda_low = (obs_q.size() - 1 != nack_at);
                else             slave_sda_low = 1'b0;
            end
            prev_scl = scl_l;
            prev_sda = sda_l;
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        int   n, ew;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk_rng("latency", cyc - e.accept, e.lo, e.hi);
                    chk("nack", nack, e.nkf);
                    if (e.nkf) chk("nack_byte", nack_byte, e.nki);
                    chk("start_cond", start_cnt, 1);
                    chk("stop_cond", stop_cnt, 1);
                    chk("wire_bytes", obs_q.size(), e.nwire);
                    n = (obs_q.size() < e.nwire) ? obs_q.size() : e.nwire;
                    for (int i = 0; i < n; i++) begin
                        ew = (i == 0) ? (int'(DEV) * 2) : ((int'(e.w) >> (8*(NB-i))) & 255);
                        chk($sformatf("byte%0d", i), obs_q[i], ew);
                    end
                end
                chk("busy_at_done", busy, 0);
                chk("scl_released", scl_oe, 0);
                chk("sda_released", sda_oe, 0);
                obs_q.delete();
                start_cnt = 0;
                stop_cnt  = 0;
                @(negedge clk);
                chk("done_one_cycle", done, 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [8*NB-1:0] w, input int nk, input bit strch);
        exp_t e;
        int   k;
        k        = (nk >= 0) ? nk : NB;
        e.w      = w;
        e.nwire  = k + 1;
        e.nkf    = (nk >= 0);
        e.nki    = nk;
        e.lo     = lat_for(k) - 1;
        e.hi     = lat_for(k) + 1;
        if (strch && k >= 1) begin
            e.lo += 45;
            e.hi += 53;
        end
        nack_at       = nk;
        stretch_armed = strch;
        wdata         = w;
        start         = 1'b1;
        e.accept      = cyc + 1;
        last_accept   = e.accept;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("nack_clr_on_accept", nack, 0);
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [8*NB-1:0] w);
        start = 1'b1;
        wdata = w;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [8*NB-1:0] w;
        int              nk;

        repeat (3) @(negedge clk);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        chk("rst_nack_byte", nack_byte, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // nominal write
        issue(16'h1E00, -1, 0);
        wait_idle(2000);

        // address NACK
        issue(16'hA55A, 0, 0);
        wait_idle(2000);

        // last-byte NACK, then nack must hold until the next start clears it
        issue(16'h1234, 2, 0);
        wait_idle(2000);
        chk("nack_held", nack, 1);

        // start while busy: mid-frame pulses and one in the done cycle
        issue(16'hC3A5, -1, 0);
        wait_cyc(last_accept + 10);
        pulse_start(16'hFFFF);
        wait_cyc(last_accept + 200);
        pulse_start(16'h0F0F);
        wait_cyc(last_accept + lat_for(NB) - 1);
        pulse_start(16'h5555);
        wait_idle(2000);
        repeat (30) @(negedge clk);
        chk("no_second_txn", busy, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        // clock stretching during bit 3 of byte 1
        stretch_done = 0;
        stretch_bad  = 0;
        issue(16'h1E00, -1, 1);
        wait_idle(3000);
        chk("stretch_occurred", stretch_done, 1);
        chk("stretch_sda_stable", stretch_bad, 0);

        // reset mid-frame during byte 1
        issue(16'h1E00, -1, 0);
        wait_cyc(last_accept + 200);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_scl_oe", scl_oe, 0);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_nack", nack, 0);
        reset = 1'b1;
        @(posedge clk);
        exp_q.delete();
        obs_q.delete();
        start_cnt     = 0;
        stop_cnt      = 0;
        in_frame      = 0;
        bitcnt        = 0;
        slave_sda_low = 1'b0;
        repeat (3) @(negedge clk);
        issue(16'h1E00, -1, 0);
        wait_idle(2000);

        // randomized transactions with occasional NACKs
        for (int t = 0; t < 10; t++) begin
            w  = 16'($urandom);
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB)) : -1;
            issue(w, nk, 0);
            wait_idle(2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
